// File: rtl/regsel_pipe.sv
// rtl/regsel_pipe.sv - register-file select sequencer with write-back delay pipe and RAW hazard detect
//
// Decodes source and destination register numbers into one-hot select buses
// for a 32x32 register file. Destination selects travel through a DEPTH-stage
// pipe so Dselect lines up with write data produced later in the pipeline.
//
// Ports:
//   clk      - clock, all state on rising edge
//   rst_n    - synchronous active-low reset
//   valid    - decode-stage instruction present
//   rs, rt   - A/B source register numbers
//   rd       - destination register number
//   wr_en    - instruction writes rd
//   stall    - hold decode, inject a bubble into the write pipe
//   flush    - kill every in-flight write
//   Aselect  - registered one-hot A read select
//   Bselect  - registered one-hot B read select
//   Dselect  - registered one-hot write select (last pipe stage)
//   hazard   - combinational read-after-write hazard flag
module regsel_pipe #(
    parameter int DEPTH = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic        wr_en,
    input  logic        stall,
    input  logic        flush,
    output logic [31:0] Aselect,
    output logic [31:0] Bselect,
    output logic [31:0] Dselect,
    output logic        hazard
);

    // Stages 1..DEPTH-1 hold {write bit, rd}. Stage DEPTH is Dselect itself,
    // stored already decoded; a bubble there is bit 0, which the register
    // file ignores because register 0 has no storage.
    logic [DEPTH-1:1]      st_wr;
    logic [DEPTH-1:1][4:0] st_rd;

    logic accept;
    assign accept = valid & ~stall & ~flush;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            Aselect <= 32'h1;
            Bselect <= 32'h1;
            Dselect <= 32'h1;
            st_wr   <= '0;
            st_rd   <= '0;
        end else if (flush) begin
            // Whatever Dselect shows this cycle is still captured by the
            // register file on this edge; only younger entries are killed.
            Dselect <= 32'h1;
            st_wr   <= '0;
            st_rd   <= '0;
        end else begin
            if (accept) begin
                Aselect  <= 32'h1 << rs;
                Bselect  <= 32'h1 << rt;
                st_wr[1] <= wr_en & (rd != 5'd0);
                st_rd[1] <= rd;
            end else begin
                st_wr[1] <= 1'b0;
                st_rd[1] <= 5'd0;
            end
            for (int i = 2; i < DEPTH; i++) begin
                st_wr[i] <= st_wr[i-1];
                st_rd[i] <= st_rd[i-1];
            end
            Dselect <= st_wr[DEPTH-1] ? (32'h1 << st_rd[DEPTH-1]) : 32'h1;
        end
    end

    logic match_s;
    logic match_t;

    always_comb begin
        match_s = Dselect[rs];
        match_t = Dselect[rt];
        for (int i = 1; i < DEPTH; i++) begin
            if (st_wr[i] && (st_rd[i] == rs)) match_s = 1'b1;
            if (st_wr[i] && (st_rd[i] == rt)) match_t = 1'b1;
        end
        // Register 0 is excluded here; this also masks the bubble bit in Dselect.
        hazard = valid & (((rs != 5'd0) & match_s) | ((rt != 5'd0) & match_t));
    end

endmodule

// File: tb/tb_regsel_pipe.sv
// tb/tb_regsel_pipe.sv - self-checking random and directed bench for regsel_pipe
module tb_regsel_pipe;
    localparam int DEPTH = 3;
    localparam int N     = 4000;

    logic        clk = 1'b0;
    logic        rst_n, valid, wr_en, stall, flush;
    logic [4:0]  rs, rt, rd;
    logic [31:0] Aselect, Bselect, Dselect;
    logic        hazard;

    regsel_pipe #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .valid(valid), .rs(rs), .rt(rt), .rd(rd),
        .wr_en(wr_en), .stall(stall), .flush(flush),
        .Aselect(Aselect), .Bselect(Bselect), .Dselect(Dselect), .hazard(hazard)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: per-edge log of what was accepted, plus the most
    // recent edge at which a reset or flush killed everything in flight.
    bit         acc [N];
    bit         wrb [N];
    logic [4:0] rdv [N];
    int         edge_n    = -1;
    int         last_kill = -1;
    logic [4:0] a_idx = 5'd0;
    logic [4:0] b_idx = 5'd0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h (edge %0d)", tag, got, exp, edge_n);
        end
    endtask

    function automatic bit live_write(input int m);
        return (m >= 0) && (m >= last_kill) && acc[m] && wrb[m] && (rdv[m] != 5'd0);
    endfunction

    // Instruction accepted at edge m shows on Dselect after edge m+DEPTH-1.
    function automatic logic [31:0] exp_d();
        int m = edge_n - DEPTH + 1;
        if (live_write(m)) return 32'h1 << rdv[m];
        return 32'h1;
    endfunction

    function automatic logic exp_haz();
        bit h = 1'b0;
        for (int m = edge_n - DEPTH + 1; m <= edge_n; m++) begin
            if (live_write(m)) begin
                if ((rs != 5'd0) && (rdv[m] == rs)) h = 1'b1;
                if ((rt != 5'd0) && (rdv[m] == rt)) h = 1'b1;
            end
        end
        return valid && h;
    endfunction

    task automatic step(input logic r, input logic v, input logic s, input logic f,
                        input logic w, input logic [4:0] a, input logic [4:0] b,
                        input logic [4:0] d);
        rst_n = r; valid = v; stall = s; flush = f; wr_en = w;
        rs = a; rt = b; rd = d;
        @(negedge clk);
        if (edge_n >= 0) begin
            check("aselect", Aselect, 32'h1 << a_idx);
            check("bselect", Bselect, 32'h1 << b_idx);
            check("dselect", Dselect, exp_d());
            check("hazard", {31'd0, hazard}, {31'd0, exp_haz()});
        end
        @(posedge clk);
        edge_n++;
        if (edge_n >= N) begin
            $display("FAIL edge_budget got=%0d exp<%0d", edge_n, N);
            $fatal(1);
        end
        acc[edge_n] = 1'b0;
        wrb[edge_n] = 1'b0;
        rdv[edge_n] = 5'd0;
        if (!rst_n) begin
            last_kill = edge_n;
            a_idx = 5'd0;
            b_idx = 5'd0;
        end else if (flush) begin
            last_kill = edge_n;
        end else if (valid && !stall) begin
            acc[edge_n] = 1'b1;
            wrb[edge_n] = wr_en;
            rdv[edge_n] = rd;
            a_idx = rs;
            b_idx = rt;
        end
        #1;
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    endtask

    initial begin
        // Reset held for two edges while a write is being presented.
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 5'd0, 5'd7);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 5'd0, 5'd7);
        check("rst_a", Aselect, 32'h1);
        check("rst_b", Bselect, 32'h1);
        check("rst_d", Dselect, 32'h1);
        idle();
        idle();
        idle();
        check("rst_d_later", Dselect, 32'h1);

        // Basic decode: accept at edge k, Dselect only after edge k+2.
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd3, 5'd31, 5'd9);
        check("basic_a", Aselect, 32'h8);
        check("basic_b", Bselect, 32'h8000_0000);
        idle();
        check("basic_d_k1", Dselect, 32'h1);
        idle();
        check("basic_d_k2", Dselect, 32'h200);
        idle();
        check("basic_d_k3", Dselect, 32'h1);

        // Hazard window for rd=4 read back as rs=4 (no further writes).
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd4);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd4, 5'd0, 5'd0);
        check("haz_after", {31'd0, hazard}, 32'h0);
        // rd=0 write never raises hazard on rs=0.
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);

        // Stall: rd=6 drains while decode holds.
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd2, 5'd2, 5'd6);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 5'd1, 5'd1, 5'd1);
        check("stall_a_hold", Aselect, 32'h4);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 5'd1, 5'd1, 5'd1);
        check("stall_d", Dselect, 32'h40);
        idle();
        check("stall_bubble1", Dselect, 32'h1);
        idle();
        check("stall_bubble2", Dselect, 32'h1);

        // Flush after 10, 11, 12; 13 presented with the flush.
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd10);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd11);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd12);
        check("flush_shown", Dselect, 32'h400);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd0, 5'd0, 5'd13);
        for (int i = 0; i < 3; i++) begin
            check("flush_bubble", Dselect, 32'h1);
            idle();
        end

        // No-write instruction to r8, then read r8.
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd8);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd8, 5'd8, 5'd0);
        check("nowrite_haz", {31'd0, hazard}, 32'h0);
        idle();
        idle();
        check("nowrite_d", Dselect, 32'h1);

        // Randomized traffic; small register range keeps hazards frequent.
        for (int i = 0; i < 2500; i++) begin
            logic       r, v, s, f, w;
            logic [4:0] a, b, d;
            r = ($urandom_range(0, 99) != 0);
            v = ($urandom_range(0, 3) != 0);
            s = ($urandom_range(0, 4) == 0);
            f = ($urandom_range(0, 15) == 0);
            w = ($urandom_range(0, 4) != 0);
            if ($urandom_range(0, 3) == 0) begin
                a = 5'($urandom); b = 5'($urandom); d = 5'($urandom);
            end else begin
                a = 5'($urandom_range(0, 5));
                b = 5'($urandom_range(0, 5));
                d = 5'($urandom_range(0, 5));
            end
            step(r, v, s, f, w, a, b, d);
        end
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/regsel_pipe.md
# regsel_pipe

Register-select sequencer that drives the select side of the 32x32 register file. It decodes 5-bit source and destination register numbers from the decode stage into the one-hot `Aselect`, `Bselect` and `Dselect` buses, and delays the destination select through a write-back pipeline. It also reports read-after-write hazards against in-flight destinations so that pipeline control can stall. It sits between instruction decode and the register file; `dbus` write data is supplied elsewhere and must be aligned to `Dselect`.

## Interface
- `DEPTH`, 3: number of register stages from decode acceptance to the `Dselect` output. Legal range is 2..6.
- `clk` input 1: clock. All state updates on the rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `valid` input 1: decode-stage instruction present.
- `rs` input 5: A-port source register number.
- `rt` input 5: B-port source register number.
- `rd` input 5: destination register number.
- `wr_en` input 1: instruction writes `rd`.
- `stall` input 1: hold the decode stage; insert a bubble into the write pipeline.
- `flush` input 1: kill all in-flight writes.
- `Aselect` output 32: one-hot A read select, registered.
- `Bselect` output 32: one-hot B read select, registered.
- `Dselect` output 32: one-hot write select, registered, last pipeline stage.
- `hazard` output 1: combinational RAW-hazard flag.

## Operation
- **Accept condition.** `valid & ~stall & ~flush` at a rising edge.
- **On accept:**
  - `Aselect` <= 1<<`rs`.
  - `Bselect` <= 1<<`rt`.
  - Pipe stage 1 <= {`wr_en & (rd!=0)`, `rd`}.
- **Bubbles.** A bubble is a stage entry with its write bit equal to 0.
- **Not accepted, no stall, no flush (`valid`=0).** `Aselect` and `Bselect` hold. Stage 1 <= bubble.
- **Stall without flush.**
  - `Aselect` and `Bselect` hold.
  - Stage 1 <= bubble.
  - Stages 2..`DEPTH` keep advancing, so older writes drain.
- **Flush.**
  - Every stage 1..`DEPTH` <= bubble on the same edge.
  - `Aselect` and `Bselect` hold.
  - Flush wins over `valid` and over `stall`.
- **Shift.** Stage i+1 <= stage i each edge, for i = 1..`DEPTH`-1.
- **`Dselect` encoding.**
  - If stage `DEPTH` write bit = 1: `Dselect` = 1<<rd.
  - Otherwise: `Dselect` = 32'h0000_0001.
  - Bit 0 has no storage in the register file, so the write is discarded.
- **One-hot invariant.** Exactly one bit of each select bus is set at all times.
- **Register 0 destination.** `rd`=0 is treated as no write. It never reaches `Dselect` as a real write and never raises `hazard`.
- **Hazard sources.** `hazard` = `valid` & ((`rs`!=0 & match(`rs`)) | (`rt`!=0 & match(`rt`))).
- **Hazard match.** match(r) is true when any stage 1..`DEPTH` holds write bit 1 with rd==r.
- **Hazard effect.** `hazard` does not stall by itself; external control drives `stall`.

## Timing
- **Reset.** Any edge with `rst_n`=0 sets:
  - `Aselect` = `Bselect` = `Dselect` = 32'h0000_0001.
  - All stages = bubble.
  - `hazard` = 0 (it is combinational from bubbles).
- **Reset mid-operation.** All in-flight writes are dropped; there is no partial write.
- **Read latency.** If an instruction is accepted at edge k, `Aselect` and `Bselect` are valid from just after edge k until the next accept.
- **Write latency.** For an instruction accepted at edge k:
  - `Dselect` shows its rd after edge k+`DEPTH`-1.
  - `Dselect` holds that value for exactly one cycle.
  - The register file captures the write at edge k+`DEPTH`.
- **Flush timing.** Flush asserted in the cycle before edge t:
  - The `Dselect` value shown in that cycle is still written at edge t.
  - `Dselect` = 32'h1 from after edge t for `DEPTH` cycles, unless new instructions are accepted.
- **Back-to-back accepts.** One accept per cycle is allowed; `Dselect` then changes every cycle.
- **Hazard window.** `hazard` responds in the same cycle as its inputs. It deasserts in the cycle after the matching entry has left stage `DEPTH`.

## Test plan
- **Reset.** `rst_n`=0 for 2 edges, with `valid`=1, `rs`=5, `rd`=7, `wr_en`=1 -> all selects = 32'h1 and `hazard`=0 after release; the first `Dselect` write appears only after a fresh accept.
- **Basic decode.** Accept `rs`=3, `rt`=31, `rd`=9, `wr_en`=1 at edge k (`DEPTH`=3) -> `Aselect`=32'h8 and `Bselect`=32'h8000_0000 after edge k; `Dselect`=32'h200 only in the cycle after edge k+2; 32'h1 otherwise.
- **Hazard.**
  - Accept `rd`=4, then present `rs`=4 -> `hazard`=1 for the next 3 cycles while the entry is in flight, then 0.
  - `rs`=0 or `rd`=0 -> never asserts.
- **Stall.** Accept `rd`=6, then `stall`=1 for 2 cycles with `rs`=1 -> `Aselect` holds its prior value; `Dselect`=32'h40 still appears at edge k+2; two bubbles (32'h1) follow.
- **Flush.** Accept `rd`=10, 11, 12 on consecutive edges, then `flush`=1 with `valid`=1 and `rd`=13 -> the `Dselect` write shown in the flush cycle completes; 11, 12 and 13 never appear; `Dselect`=32'h1 for 3 cycles.
- **No-write instruction.** `wr_en`=0 with `rd`=8 -> `Dselect` stays 32'h1; `hazard`=0 for a later `rs`=8.
